// File: rtl/mem_rr_scheduler.sv
// Round-robin arbiter sharing one memory port between the instruction-fetch and data requesters.
// Optional watchdog: define MEM_TIMEOUT_EN to turn a hung transaction into an error response.

module mem_rr_scheduler_checker #(
  parameter int unsigned LIMIT = 32'd255
) (
  input logic clock,
  input logic reset,
  input logic i_drop,
  input logic d_drop
);
  // Watchdog limit must fit the 16-bit counter
  a_limit_range : assert property (@(posedge clock) (LIMIT >= 32'd1) && (LIMIT <= 32'd65535));
  // A request pulse on a full or granted port is a requester protocol violation
  a_i_no_drop : assert property (@(posedge clock) disable iff (reset) !i_drop);
  a_d_no_drop : assert property (@(posedge clock) disable iff (reset) !d_drop);
endmodule

module mem_rr_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        imemory_valid,
  input  logic        imemory_instr,
  input  logic [31:0] imemory_addr,
  input  logic [31:0] imemory_wdata,
  input  logic [3:0]  imemory_wstrb,
  output logic [31:0] imemory_rdata,
  output logic        imemory_error,
  output logic        imemory_ready,
  input  logic        dmemory_valid,
  input  logic        dmemory_instr,
  input  logic [31:0] dmemory_addr,
  input  logic [31:0] dmemory_wdata,
  input  logic [3:0]  dmemory_wstrb,
  output logic [31:0] dmemory_rdata,
  output logic        dmemory_error,
  output logic        dmemory_ready,
  output logic        memory_valid,
  output logic        memory_instr,
  output logic [31:0] memory_addr,
  output logic [31:0] memory_wdata,
  output logic [3:0]  memory_wstrb,
  input  logic [31:0] memory_rdata,
  input  logic        memory_error,
  input  logic        memory_ready
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state_r;
  logic        last_r;
  logic        owner_r;
  logic        i_pend_r, i_instr_r, d_pend_r, d_instr_r;
  logic [31:0] i_addr_r, i_wdata_r, d_addr_r, d_wdata_r;
  logic [3:0]  i_wstrb_r, d_wstrb_r;

  logic grant_i_s, grant_d_s, busy_s, resp_s, timeout_s;
  logic i_cap_s, d_cap_s;

  assign busy_s = (state_r == BUSY);
  assign resp_s = busy_s && memory_ready;

`ifdef MEM_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 32'd1);
  logic [15:0] cnt_r;
  // The real response wins over a watchdog expiry in the same cycle
  assign timeout_s = busy_s && !memory_ready && (cnt_r == TO_LAST);
`else
  assign timeout_s = 1'b0;
`endif

  // Grant selection: on a tie, serve the port that did not go last
  always_comb begin
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    if (state_r == IDLE) begin
      if (d_pend_r && (!i_pend_r || !last_r)) begin
        grant_d_s = 1'b1;
      end else begin
        grant_i_s = i_pend_r;
      end
    end else begin
      grant_i_s = 1'b0;
    end
  end

  // A draining slot may be refilled in the same cycle; the port in service may not
  assign i_cap_s = imemory_valid && (!i_pend_r || grant_i_s) && !(busy_s && !owner_r);
  assign d_cap_s = dmemory_valid && (!d_pend_r || grant_d_s) && !(busy_s && owner_r);

  // Shared-port request, all fields zero unless a grant is issued this cycle
  always_comb begin
    memory_valid = grant_i_s || grant_d_s;
    memory_instr = 1'b0;
    memory_addr  = 32'h0;
    memory_wdata = 32'h0;
    memory_wstrb = 4'h0;
    if (grant_d_s) begin
      memory_instr = d_instr_r;
      memory_addr  = d_addr_r;
      memory_wdata = d_wdata_r;
      memory_wstrb = d_wstrb_r;
    end else if (grant_i_s) begin
      memory_instr = i_instr_r;
      memory_addr  = i_addr_r;
      memory_wdata = i_wdata_r;
      memory_wstrb = i_wstrb_r;
    end else begin
      memory_instr = 1'b0;
    end
  end

  // Response routing to the owner; a watchdog expiry reports error with zero data
  always_comb begin
    imemory_ready = (resp_s || timeout_s) && !owner_r;
    dmemory_ready = (resp_s || timeout_s) && owner_r;
    imemory_rdata = 32'h0;
    dmemory_rdata = 32'h0;
    imemory_error = timeout_s && !owner_r;
    dmemory_error = timeout_s && owner_r;
    if (resp_s) begin
      if (owner_r) begin
        dmemory_rdata = memory_rdata;
        dmemory_error = memory_error;
      end else begin
        imemory_rdata = memory_rdata;
        imemory_error = memory_error;
      end
    end else begin
      imemory_rdata = 32'h0;
    end
  end

  // FSM, grant pointer and request slots
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= IDLE;
      last_r    <= 1'b0;
      owner_r   <= 1'b0;
      i_pend_r  <= 1'b0;
      i_instr_r <= 1'b0;
      i_addr_r  <= 32'h0;
      i_wdata_r <= 32'h0;
      i_wstrb_r <= 4'h0;
      d_pend_r  <= 1'b0;
      d_instr_r <= 1'b0;
      d_addr_r  <= 32'h0;
      d_wdata_r <= 32'h0;
      d_wstrb_r <= 4'h0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_d_s || grant_i_s) begin
            state_r <= BUSY;
            last_r  <= grant_d_s;
            owner_r <= grant_d_s;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (resp_s || timeout_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= BUSY;
          end
        end
        default: state_r <= IDLE;
      endcase
      if (i_cap_s) begin
        i_pend_r  <= 1'b1;
        i_instr_r <= imemory_instr;
        i_addr_r  <= imemory_addr;
        i_wdata_r <= imemory_wdata;
        i_wstrb_r <= imemory_wstrb;
      end else if (grant_i_s) begin
        i_pend_r <= 1'b0;
      end else begin
        i_pend_r <= i_pend_r;
      end
      if (d_cap_s) begin
        d_pend_r  <= 1'b1;
        d_instr_r <= dmemory_instr;
        d_addr_r  <= dmemory_addr;
        d_wdata_r <= dmemory_wdata;
        d_wstrb_r <= dmemory_wstrb;
      end else if (grant_d_s) begin
        d_pend_r <= 1'b0;
      end else begin
        d_pend_r <= d_pend_r;
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  // Watchdog counts BUSY cycles since the grant
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r <= 16'h0;
    end else if (grant_i_s || grant_d_s) begin
      cnt_r <= 16'h0;
    end else if (busy_s) begin
      cnt_r <= cnt_r + 16'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end
`endif

  mem_rr_scheduler_checker #(.LIMIT(TIMEOUT_CYCLES)) u_checker (
    .clock  (clock),
    .reset  (reset),
    .i_drop (imemory_valid && !i_cap_s),
    .d_drop (dmemory_valid && !d_cap_s)
  );

endmodule

// File: tb/tb_mem_rr_scheduler.sv
// Table-driven cycle-by-cycle check of mem_rr_scheduler plus hand-written watchdog sequences.
module tb_mem_rr_scheduler;
  logic clock = 1'b0;
  logic reset;
  logic iv, ii, dv, di, mv, mi, mr, me, ir, ie, dr, de;
  logic [31:0] ia, iw, da, dw, ma, mw, mrd, ird, drd;
  logic [3:0] is, ds, ms;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  mem_rr_scheduler #(.TIMEOUT_CYCLES(32'd8)) dut (
    .clock(clock), .reset(reset),
    .imemory_valid(iv), .imemory_instr(ii), .imemory_addr(ia), .imemory_wdata(iw), .imemory_wstrb(is),
    .imemory_rdata(ird), .imemory_error(ie), .imemory_ready(ir),
    .dmemory_valid(dv), .dmemory_instr(di), .dmemory_addr(da), .dmemory_wdata(dw), .dmemory_wstrb(ds),
    .dmemory_rdata(drd), .dmemory_error(de), .dmemory_ready(dr),
    .memory_valid(mv), .memory_instr(mi), .memory_addr(ma), .memory_wdata(mw), .memory_wstrb(ms),
    .memory_rdata(mrd), .memory_error(me), .memory_ready(mr)
  );

  typedef struct {
    logic rst; logic iv; logic ii; logic [31:0] ia;
    logic dv; logic [31:0] da; logic [31:0] dw; logic [3:0] ds;
    logic mr; logic [31:0] mrd; logic me;
    logic emv; logic emi; logic [31:0] ema; logic [31:0] emw; logic [3:0] ems;
    logic eir; logic eie; logic [31:0] eird;
    logic edr; logic ede; logic [31:0] edrd;
  } row_t;

  row_t tv [32];

  function automatic row_t zrow();
    row_t r;
    r = '{'0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0};
    return r;
  endfunction

  // Drive one cycle of inputs just after the edge, then check the combinational outputs
  task automatic apply(input row_t v, input string name);
    logic [69:0] got_m, exp_m;
    logic [67:0] got_r, exp_r;
    @(posedge clock);
    #1;
    reset = v.rst; iv = v.iv; ii = v.ii; ia = v.ia; iw = 32'h0; is = 4'h0;
    dv = v.dv; di = 1'b0; da = v.da; dw = v.dw; ds = v.ds;
    mr = v.mr; mrd = v.mrd; me = v.me;
    #1;
    got_m = {mv, mi, ma, mw, ms};
    exp_m = {v.emv, v.emi, v.ema, v.emw, v.ems};
    got_r = {ir, ie, ird, dr, de, drd};
    exp_r = {v.eir, v.eie, v.eird, v.edr, v.ede, v.edrd};
    n_tests++;
    if (got_m !== exp_m || got_r !== exp_r) begin
      n_fail++;
      $display("FAIL %s: mem got %h want %h, resp got %h want %h", name, got_m, exp_m, got_r, exp_r);
    end
  endtask

  row_t r;

  initial begin
    reset = 1'b1; iv = 1'b0; ii = 1'b0; ia = 32'h0; iw = 32'h0; is = 4'h0;
    dv = 1'b0; di = 1'b0; da = 32'h0; dw = 32'h0; ds = 4'h0;
    mr = 1'b0; mrd = 32'h0; me = 1'b0;
    @(posedge clock);

    //        rst iv  ii  ia            dv  da            dw            ds     mr  mrd           me   emv emi ema           emw           ems    eir eie eird          edr ede edrd
    tv[0]  = '{'1, '0, '0, 32'h0,        '0, 32'h0,        32'h0,        4'h0, '0, 32'h0,        '0,  '0, '0, 32'h0,        32'h0,        4'h0, '0, '0, 32'h0,        '0, '0, 32'h0};
    tv[1]  = '{'0, '1, '1, 32'h100,      '0, 32'h0,        32'h0,        4'h0, '0, 32'h0,        '0,  '0, '0, 32'h0,        32'h0,        4'h0, '0, '0, 32'h0,        '0, '0, 32'h0};
    tv[2]  = '{'0, '0, '0, 32'h0,        '0, 32'h0,        32'h0,        4'h0, '0, 32'h0,        '0,  '1, '1, 32'h100,      32'h0,        4'h0, '0, '0, 32'h0,        '0, '0, 32'h0};
    tv[3]  = '{'0, '0, '0, 32'h0,        '0, 32'h0,        32'h0,        4'h0, '0, 32'h0,        '0,  '0, '0, 32'h0,        32'h0,        4'h0, '0, '0, 32'h0,        '0, '0, 32'h0};
    tv[4]  = '{'0, '0, '0, 32'h0,        '0, 32'h0,        32'h0,        4'h0, '0, 32'h0,        '0,  '0, '0, 32'h0,        32'h0,        4'h0, '0, '0, 32'h0,        '0, '0, 32'h0};
    tv[5]  = '{'0, '0, '0, 32'h0,        '0, 32'h0,        32'h0,        4'h0, '1, 32'hDEADBEEF, '0,  '0, '0, 32'h0,        32'h0,        4'h0, '1, '0, 32'hDEADBEEF, '0, '0, 32'h0};
    tv[6]  = '{'0, '0, '0, 32'h0,        '0, 32'h0,        32'h0,        4'h0, '0, 32'h0,        '0,  '0, '0, 32'h0,        32'h0,        4'h0, '0, '0, 32'h0,        '0, '0, 32'h0};
    tv[7]  = '{'1, '0, '0, 32'h0,        '0, 32'h0,        32'h0,        4'h0, '0, 32'h0,        '0,  '0, '0, 32'h0,        32'h0,        4'h0, '0, '0, 32'h0,        '0, '0, 32'h0};
    tv[8]  = '{'0, '1, '1, 32'h100,      '1, 32'h80000000, 32'h12345678, 4'hF, '0, 32'h0,        '0,  '0, '0, 32'h0,        32'h0,        4'h0, '0, '0, 32'h0,        '0, '0, 32'h0};
    tv[9]  = '{'0, '0, '0, 32'h0,        '0, 32'h0,        32'h0,        4'h0, '0, 32'h0,        '0,  '1, '0, 32'h80000000, 32'h12345678, 4'hF, '0, '0, 32'h0,        '0, '0, 32'h0};
    tv[10] = '{'0, '0, '0, 32'h0,        '0, 32'h0,        32'h0,        4'h0, '1, 32'h0,        '0,  '0, '0, 32'h0,        32'h0,        4'h0, '0, '0, 32'h0,        '1, '0, 32'h0};
    tv[11] = '{'0, '1, '1, 32'h104,      '1, 32'h80000004, 32'h0,        4'h0, '0, 32'h0,        '0,  '1, '1, 32'h100,      32'h0,        4'h0, '0, '0, 32'h0,        '0, '0, 32'h0};
    tv[12] = '{'0, '0, '0, 32'h0,        '0, 32'h0,        32'h0,        4'h0, '0, 32'h0,        '0,  '0, '0, 32'h0,        32'h0,        4'h0, '0, '0, 32'h0,        '0, '0, 32'h0};
    tv[13] = '{'0, '0, '0, 32'h0,        '0, 32'h0,        32'h0,        4'h0, '1, 32'h11111111, '0,  '0, '0, 32'h0,        32'h0,        4'h0, '1, '0, 32'h11111111, '0, '0, 32'h0};
    tv[14] = '{'0, '0, '0, 32'h0,        '0, 32'h0,        32'h0,        4'h0, '0, 32'h0,        '0,  '1, '0, 32'h80000004, 32'h0,        4'h0, '0, '0, 32'h0,        '0, '0, 32'h0};
    tv[15] = '{'0, '0, '0, 32'h0,        '0, 32'h0,        32'h0,        4'h0, '1, 32'h22222222, '0,  '0, '0, 32'h0,        32'h0,        4'h0, '0, '0, 32'h0,        '1, '0, 32'h22222222};
    tv[16] = '{'0, '1, '1, 32'h108,      '1, 32'h80000008, 32'hAABBCCDD, 4'h3, '0, 32'h0,        '0,  '1, '1, 32'h104,      32'h0,        4'h0, '0, '0, 32'h0,        '0, '0, 32'h0};
    tv[17] = '{'0, '0, '0, 32'h0,        '0, 32'h0,        32'h0,        4'h0, '0, 32'h0,        '0,  '0, '0, 32'h0,        32'h0,        4'h0, '0, '0, 32'h0,        '0, '0, 32'h0};
    tv[18] = '{'0, '0, '0, 32'h0,        '0, 32'h0,        32'h0,        4'h0, '1, 32'h33333333, '0,  '0, '0, 32'h0,        32'h0,        4'h0, '1, '0, 32'h33333333, '0, '0, 32'h0};
    tv[19] = '{'0, '0, '0, 32'h0,        '0, 32'h0,        32'h0,        4'h0, '0, 32'h0,        '0,  '1, '0, 32'h80000008, 32'hAABBCCDD, 4'h3, '0, '0, 32'h0,        '0, '0, 32'h0};
    tv[20] = '{'0, '0, '0, 32'h0,        '0, 32'h0,        32'h0,        4'h0, '1, 32'h0,        '0,  '0, '0, 32'h0,        32'h0,        4'h0, '0, '0, 32'h0,        '1, '0, 32'h0};
    tv[21] = '{'0, '0, '0, 32'h0,        '0, 32'h0,        32'h0,        4'h0, '0, 32'h0,        '0,  '1, '1, 32'h108,      32'h0,        4'h0, '0, '0, 32'h0,        '0, '0, 32'h0};
    tv[22] = '{'0, '0, '0, 32'h0,        '0, 32'h0,        32'h0,        4'h0, '1, 32'h44444444, '0,  '0, '0, 32'h0,        32'h0,        4'h0, '1, '0, 32'h44444444, '0, '0, 32'h0};
    tv[23] = '{'0, '0, '0, 32'h0,        '1, 32'h80000010, 32'h0,        4'h0, '0, 32'h0,        '0,  '0, '0, 32'h0,        32'h0,        4'h0, '0, '0, 32'h0,        '0, '0, 32'h0};
    tv[24] = '{'0, '0, '0, 32'h0,        '0, 32'h0,        32'h0,        4'h0, '0, 32'h0,        '0,  '1, '0, 32'h80000010, 32'h0,        4'h0, '0, '0, 32'h0,        '0, '0, 32'h0};
    tv[25] = '{'0, '0, '0, 32'h0,        '0, 32'h0,        32'h0,        4'h0, '1, 32'h0,        '1,  '0, '0, 32'h0,        32'h0,        4'h0, '0, '0, 32'h0,        '1, '1, 32'h0};
    tv[26] = '{'0, '0, '0, 32'h0,        '0, 32'h0,        32'h0,        4'h0, '1, 32'h55,       '0,  '0, '0, 32'h0,        32'h0,        4'h0, '0, '0, 32'h0,        '0, '0, 32'h0};
    tv[27] = '{'0, '1, '1, 32'h200,      '0, 32'h0,        32'h0,        4'h0, '0, 32'h0,        '0,  '0, '0, 32'h0,        32'h0,        4'h0, '0, '0, 32'h0,        '0, '0, 32'h0};
    tv[28] = '{'0, '1, '1, 32'h204,      '0, 32'h0,        32'h0,        4'h0, '0, 32'h0,        '0,  '1, '1, 32'h200,      32'h0,        4'h0, '0, '0, 32'h0,        '0, '0, 32'h0};
    tv[29] = '{'1, '0, '0, 32'h0,        '0, 32'h0,        32'h0,        4'h0, '0, 32'h0,        '0,  '0, '0, 32'h0,        32'h0,        4'h0, '0, '0, 32'h0,        '0, '0, 32'h0};
    tv[30] = '{'0, '0, '0, 32'h0,        '0, 32'h0,        32'h0,        4'h0, '1, 32'h66,       '0,  '0, '0, 32'h0,        32'h0,        4'h0, '0, '0, 32'h0,        '0, '0, 32'h0};
    tv[31] = '{'0, '0, '0, 32'h0,        '0, 32'h0,        32'h0,        4'h0, '0, 32'h0,        '0,  '0, '0, 32'h0,        32'h0,        4'h0, '0, '0, 32'h0,        '0, '0, 32'h0};

    for (int k = 0; k < 32; k++) begin
      apply(tv[k], $sformatf("vec%0d", k));
    end

`ifdef MEM_TIMEOUT_EN
    // Watchdog expiry on a data read, then a late response that must be ignored
    r = zrow(); r.dv = 1'b1; r.da = 32'h300;
    apply(r, "to_req");
    r = zrow(); r.emv = 1'b1; r.ema = 32'h300;
    apply(r, "to_grant");
    for (int k = 1; k <= 7; k++) apply(zrow(), $sformatf("to_wait%0d", k));
    r = zrow(); r.edr = 1'b1; r.ede = 1'b1;
    apply(r, "to_expire");
    apply(zrow(), "to_after");
    r = zrow(); r.mr = 1'b1; r.mrd = 32'h99;
    apply(r, "to_late_ready");
    // Real response coinciding with the watchdog limit wins
    r = zrow(); r.iv = 1'b1; r.ii = 1'b1; r.ia = 32'h400;
    apply(r, "tie_req");
    r = zrow(); r.emv = 1'b1; r.emi = 1'b1; r.ema = 32'h400;
    apply(r, "tie_grant");
    for (int k = 1; k <= 7; k++) apply(zrow(), $sformatf("tie_wait%0d", k));
    r = zrow(); r.mr = 1'b1; r.mrd = 32'h77; r.eir = 1'b1; r.eird = 32'h77;
    apply(r, "tie_resp");
`else
    // Without the watchdog a slow memory is simply waited for
    r = zrow(); r.dv = 1'b1; r.da = 32'h500;
    apply(r, "slow_req");
    r = zrow(); r.emv = 1'b1; r.ema = 32'h500;
    apply(r, "slow_grant");
    for (int k = 1; k <= 20; k++) apply(zrow(), $sformatf("slow_wait%0d", k));
    r = zrow(); r.mr = 1'b1; r.mrd = 32'hA5A5A5A5; r.edr = 1'b1; r.edrd = 32'hA5A5A5A5;
    apply(r, "slow_resp");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
